// File: rtl/sub24bit_pl.sv
`default_nettype none
// ============================================================================
// Module   : sub24bit_pl
// Purpose  : Three-stage pipelined 24-bit unsigned subtractor with borrow-in.
//            Computes diff = {1'b0,a} - {1'b0,b} - bIn (mod 2^25) as
//            a + ~b + ~bIn through a Kogge-Stone style kill/propagate/generate
//            (KPG) prefix network. diff[24] is the borrow-out.
//            Valid/ready handshake on both sides; the whole pipeline advances
//            as one unit whenever in_ready is high.
// Ports    : clk       - clock, rising edge
//            rst       - synchronous active-high reset
//            in_valid  - a, b, bIn are valid
//            in_ready  - operands accepted this cycle (~out_valid | out_ready)
//            a, b      - 24-bit unsigned minuend / subtrahend
//            bIn       - borrow-in
//            out_valid - diff is valid
//            out_ready - consumer accepts diff
//            diff      - 25-bit result, bit 24 = borrow-out
//            ovf       - signed overflow of diff[23:0] (SUB24_SIGNED_OVF_EN only)
// Options  : define SUB24_SIGNED_OVF_EN to add the registered ovf output.
// Revision : 1.0 - initial release
// ============================================================================
module sub24bit_pl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] a,
    input  logic [23:0] b,
    input  logic        bIn,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [24:0] diff
`ifdef SUB24_SIGNED_OVF_EN
    ,
    output logic        ovf
`endif
);

    // 25 prefix positions: position 0 is the carry-in, position i+1 is bit i.
    localparam int c_N = 25;

    // KPG codes: kill=00, propagate=01/10, generate=11.
    // Combine: keep the upper code unless it is propagate, then take the lower.
    function automatic logic [1:0] kpg_combine(input logic [1:0] upper,
                                               input logic [1:0] lower);
        return (upper[1] ^ upper[0]) ? lower : upper;
    endfunction

    // One prefix level with the given span.
    function automatic logic [c_N-1:0][1:0] kpg_level(input logic [c_N-1:0][1:0] prev,
                                                      input int span);
        logic [c_N-1:0][1:0] res;
        for (int i = 0; i < c_N; i++) begin
            if (i >= span) begin
                res[i] = kpg_combine(prev[i], prev[i-span]);
            end else begin
                res[i] = prev[i];
            end
        end
        return res;
    endfunction

    logic                w_adv;
    logic [c_N-1:0][1:0] w_kpg0;
    logic [c_N-1:0][1:0] w_lvl1;
    logic [c_N-1:0][1:0] w_lvl2;
    logic [c_N-1:0][1:0] w_lvl3;
    logic [c_N-1:0][1:0] w_lvl4;
    logic [c_N-1:0][1:0] w_lvl5;
    logic [24:0]         w_carry;
    logic [24:0]         w_diff;

    logic                r1_valid;
    logic [c_N-1:0][1:0] r1_kpg;
    logic [23:0]         r1_a;
    logic [23:0]         r1_b;
    logic                r2_valid;
    logic [c_N-1:0][1:0] r2_kpg;
    logic [23:0]         r2_a;
    logic [23:0]         r2_b;
    logic                r_out_valid;
    logic [24:0]         r_diff;

    assign in_ready  = ~r_out_valid | out_ready;
    assign w_adv     = in_ready;
    assign out_valid = r_out_valid;
    assign diff      = r_diff;

    // Stage 1 inputs: per-bit code is simply {a, ~b}; carry-in is generate
    // when there is no borrow (adding 1 of the two's complement), else kill.
    always_comb begin
        w_kpg0[0] = bIn ? 2'b00 : 2'b11;
        for (int i = 0; i < 24; i++) begin
            w_kpg0[i+1] = {a[i], ~b[i]};
        end
    end

    // Stage 2 logic: spans 1, 2, 4.
    assign w_lvl1 = kpg_level(r1_kpg, 1);
    assign w_lvl2 = kpg_level(w_lvl1, 2);
    assign w_lvl3 = kpg_level(w_lvl2, 4);

    // Stage 3 logic: spans 8, 16. Position 0 is never propagate, so every
    // prefix is fully resolved to kill or generate after the last level.
    assign w_lvl4 = kpg_level(r2_kpg, 8);
    assign w_lvl5 = kpg_level(w_lvl4, 16);

    always_comb begin
        for (int i = 0; i < c_N; i++) begin
            w_carry[i] = &w_lvl5[i];
        end
        w_diff[23:0] = r2_a ^ ~r2_b ^ w_carry[23:0];
        // Borrow-out is the inverse of the adder carry-out.
        w_diff[24]   = ~w_carry[24];
    end

    // Control and output registers (reset).
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid    <= 1'b0;
            r2_valid    <= 1'b0;
            r_out_valid <= 1'b0;
            r_diff      <= 25'd0;
        end else if (w_adv) begin
            r1_valid    <= in_valid;
            r2_valid    <= r1_valid;
            r_out_valid <= r2_valid;
            r_diff      <= w_diff;
        end
    end

    // Datapath registers; contents are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r1_kpg <= w_kpg0;
            r1_a   <= a;
            r1_b   <= b;
            r2_kpg <= w_lvl3;
            r2_a   <= r1_a;
            r2_b   <= r1_b;
        end
    end

`ifdef SUB24_SIGNED_OVF_EN
    logic r_ovf;
    assign ovf = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_ovf <= (r2_a[23] != r2_b[23]) && (w_diff[23] != r2_a[23]);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sub24bit_pl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub24bit_pl
// Purpose  : Self-checking scoreboard bench for sub24bit_pl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sub24bit_pl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] a = '0;
    logic [23:0] b = '0;
    logic        bIn = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [24:0] diff;
`ifdef SUB24_SIGNED_OVF_EN
    logic        ovf;
`endif

    sub24bit_pl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bIn       (bIn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff)
`ifdef SUB24_SIGNED_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] d;
        logic        o;
        int          cyc;
        bit          lat;
        int          seq;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   chk_lat  = 1'b0;
    int   seq_mode = 0;
    int   last_out_cyc = 0;
    bit   hold_prev = 1'b0;
    logic [24:0] prev_diff = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [24:0] model_diff(input logic [23:0] ta, input logic [23:0] tb_, input logic tbin);
        logic [24:0] r;
        r = {1'b0, ta} - {1'b0, tb_} - {24'd0, tbin};
        return r;
    endfunction

    // Monitor / scoreboard: everything sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_diff", {7'd0, diff}, {7'd0, prev_diff});
            end
            if (out_valid && !out_ready)
                chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            if (out_valid && out_ready) begin
                chk("sb_nonempty", {31'd0, (sb.size() != 0)}, 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("diff", {7'd0, diff}, {7'd0, e.d});
`ifdef SUB24_SIGNED_OVF_EN
                    chk("ovf", {31'd0, ovf}, {31'd0, e.o});
`endif
                    if (e.lat)
                        chk("latency", cyc - e.cyc, 32'd3);
                    if (e.seq == 2)
                        chk("b2b_spacing", cyc - last_out_cyc, 32'd1);
                    last_out_cyc = cyc;
                end
            end
            if (in_valid && in_ready) begin
                exp_t n;
                n.d   = model_diff(a, b, bIn);
                n.o   = (a[23] != b[23]) && (n.d[23] != a[23]);
                n.cyc = cyc;
                n.lat = chk_lat;
                n.seq = seq_mode;
                sb.push_back(n);
            end
            hold_prev = out_valid && !out_ready;
            prev_diff = diff;
        end
    end

    // Present one operand set and hold it until accepted (bounded).
    task automatic send(input logic [23:0] ta, input logic [23:0] tb_, input logic tbin);
        int  n;
        logic acc;
        n = 0;
        in_valid = 1'b1;
        a = ta;
        b = tb_;
        bIn = tbin;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("send_timeout", {31'd0, acc}, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        int  c0;
        bit  done;
        // Reset
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_diff", {7'd0, diff}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Single op with latency check, then boundary vectors
        chk_lat = 1'b1;
        send(24'h8C6315, 24'h5AD6BB, 1'b0);
        chk_lat = 1'b0;
        drain();
        send(24'h000000, 24'h000000, 1'b1);
        send(24'h000005, 24'h000003, 1'b1);
        send(24'h7FFFFF, 24'hFFFFFF, 1'b0);
        send(24'h000005, 24'h000003, 1'b0);
        send(24'hFFFFFF, 24'h000000, 1'b0);
        send(24'h000000, 24'hFFFFFF, 1'b1);
        send(24'h800000, 24'h000001, 1'b0);
        drain();

        // Eight back-to-back
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            seq_mode = (i == 0) ? 1 : 2;
            send(24'h100000 * i + 24'h0ABCDE, 24'h012345 * (i + 1), i[0]);
        end
        seq_mode = 0;
        chk("b2b_accept_cycles", cyc - c0, 32'd8);
        drain();

        // Stall: out_ready low for 5 cycles once out_valid rises
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send(24'h00F000 + i, 24'h000F00 * i, 1'b0);
                in_valid = 1'b0;
            end
            begin
                int n;
                n = 0;
                while (!out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                chk("stall_seen_valid", {31'd0, out_valid}, 32'd1);
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two operations in flight
        send(24'h123456, 24'h000001, 1'b0);
        send(24'h654321, 24'h000002, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_diff", {7'd0, diff}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (8) @(posedge clk);
        #1;

        // Random traffic with random back-pressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++)
                    send(24'($urandom), 24'($urandom), 1'($urandom_range(0, 1)));
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                int n;
                n = 0;
                while (!done && n < 2000) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                    n++;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
